snake_dir_scheduler: RTL and testbench
======================================

// Module: snake_dir_scheduler
// PURPOSE
//  Sequences decoded PS/2 keyboard events into game commands for the snake engine.
//  Consumes one (scancode, released) event per keyboard handshake and acks it.
//  Queues direction presses, releases one per game tick, and issues start/reset pulses.
//  Sits between the PS/2 receiver and the snake game FSM.
// PARAMETERS
//  QDEPTH     4      direction queue depth; power of 2, range 2..16
//  INIT_DIR   2'd1   cur_dir after reset and after each flush (RIGHT)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  kbd_valid    in   1   receiver holds an unread event; level, held until kbd_ack
//  kbd_code     in   8   make/break scancode; valid while kbd_valid=1
//  kbd_released in   1   1 = break (key release) event
//  kbd_ack      out  1   one-cycle read strobe to the receiver
//  tick         in   1   one-cycle game-step strobe
//  cur_dir      out  2   applied direction: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT
//  dir_upd      out  1   one-cycle pulse; cur_dir changed on this tick
//  start_req    out  1   one-cycle pulse; game start
//  reset_req    out  1   one-cycle pulse; game abort/reset
//  running      out  1   1 while the FSM is in RUN
//  q_count      out  clog2(QDEPTH+1)  number of queued directions
//  overflow     out  1   sticky; a press was dropped because the queue was full
// BEHAVIOUR
//  Reset values: kbd_ack=0, cur_dir=INIT_DIR, dir_upd=0, start_req=0, reset_req=0,
//    running=0, q_count=0, overflow=0, FSM=IDLE.
//  Handshake: an event is taken when kbd_valid=1 and kbd_ack=0. kbd_ack=1 on the
//    next cycle only, so it never asserts on two consecutive cycles. Every event is acked,
//    including unknown codes and breaks. Event-to-ack latency is 1 cycle.
//  Break events (kbd_released=1) and unknown codes are acked and have no other effect.
//  Codes: UP 8'h75, DOWN 8'h72, LEFT 8'h6B, RIGHT 8'h74, START 8'h5A, RESET 8'h76.
//  IDLE: START -> start_req pulse, running=1, go to RUN. All other codes are ignored.
//    Ticks are ignored.
//  RUN: an arrow press pushes its direction. The push takes effect in the cycle the
//    event is taken. The push is skipped when the direction equals the reference direction
//    (queue tail, or cur_dir when the queue is empty). START is ignored.
//    RESET -> reset_req pulse, queue flush, cur_dir=INIT_DIR, overflow cleared,
//    go to IDLE, all on the same edge.
//  tick in RUN with q_count>0: pop the head into cur_dir and pulse dir_upd on the next
//    cycle. tick with an empty queue: no change, no dir_upd.
//  Simultaneous push and pop:
//    - Pop uses the pre-edge head.
//    - Push on an empty queue is stored, not bypassed.
//    - Full queue with push+pop: both occur and q_count is unchanged.
//  Full queue with push and no pop: the press is dropped and overflow is set.
//  Simultaneous RESET event and tick: RESET wins and no pop occurs.
//  rst mid-operation: all state returns to reset values on the next edge.
//    A pending kbd_valid is taken 1 cycle after rst deasserts.
// CONFIGURATION
//  SNAKE_REVERSE_FILTER_EN defined: a press equal to reference_dir^2 (180-degree reversal)
//    is dropped, without setting overflow.
//  SNAKE_REVERSE_FILTER_EN undefined: reversals are queued like any other direction.
// STRUCTURE
//  Package snake_kbd_pkg holds:
//    - direction encoding constants DIR_UP/RIGHT/DOWN/LEFT;
//    - scancode constants;
//    - FSM state constants S_IDLE/S_RUN.
//  Sub-module snake_dir_fifo: synchronous QDEPTH x 2-bit FIFO providing push, pop,
//    flush, head, tail, count, full and empty.
//  The top level holds the event FSM, ack generation, the filters and cur_dir.
// TESTING
//  1. START press in IDLE -> kbd_ack at +1, start_req pulse, running=1.
//     UP press while in IDLE -> ack only, q_count=0.
//  2. RUN; press UP, then LEFT; two ticks -> cur_dir=0, then 3, with a dir_upd pulse
//     each time.
//  3. RUN; press 5 distinct alternating directions with QDEPTH=4 -> q_count=4,
//     overflow=1, 5th dropped.
//  4. Press UP, UP -> q_count=1 (duplicate skipped). Break 8'h75 -> acked, no push.
//  5. cur_dir=RIGHT, queue empty, press LEFT -> q_count=0 with SNAKE_REVERSE_FILTER_EN
//     defined, q_count=1 without it.
//  6. RESET press coincident with tick, queue holding 3 -> reset_req pulse, q_count=0,
//     cur_dir=1, IDLE. Assert rst mid-RUN -> all outputs at reset values.

Source files
------------

// File: rtl/snake_kbd_pkg.sv
// ============================================================================
// snake_kbd_pkg : direction encodings, scancodes and FSM states shared by the
//                 snake keyboard scheduler. Rev 1.0
// ============================================================================
`default_nettype none

package snake_kbd_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_START = 8'h5A;
    localparam logic [7:0] SC_RESET = 8'h76;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Returns {is_arrow, direction}.
    function automatic logic [2:0] decode_arrow(input logic [7:0] code);
        case (code)
            SC_UP:    return {1'b1, DIR_UP};
            SC_RIGHT: return {1'b1, DIR_RIGHT};
            SC_DOWN:  return {1'b1, DIR_DOWN};
            SC_LEFT:  return {1'b1, DIR_LEFT};
            default:  return 3'b000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/snake_dir_fifo.sv
// ============================================================================
// snake_dir_fifo : synchronous QDEPTH x 2-bit direction FIFO with flush and
//                  head/tail visibility. Rev 1.0
// ============================================================================
`default_nettype none

module snake_dir_fifo #(
    parameter  int QDEPTH = 4,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [1:0]    din,
    output logic [1:0]    head,
    output logic [1:0]    tail,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [1:0]    mem_q [QDEPTH];
    logic [1:0]    mem_d [QDEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    assign head  = mem_q[rd_ptr_q];
    assign tail  = mem_q[wr_ptr_q - 1'b1];
    assign count = count_q;
    assign full  = (count_q == CW'(QDEPTH));
    assign empty = (count_q == '0);

    // Caller only pushes into a full FIFO when it pops on the same edge, so the
    // write lands in the slot the head is leaving.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/snake_dir_scheduler.sv
// ============================================================================
// snake_dir_scheduler : turns PS/2 key events into queued snake directions and
//                       start/reset pulses. Optional: SNAKE_REVERSE_FILTER_EN
//                       drops 180-degree reversals. Rev 1.0
// ============================================================================
`default_nettype none

module snake_dir_scheduler
    import snake_kbd_pkg::*;
#(
    parameter  int         QDEPTH   = 4,
    parameter  logic [1:0] INIT_DIR = 2'd1,
    localparam int         CW       = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kbd_valid,
    input  logic [7:0]    kbd_code,
    input  logic          kbd_released,
    output logic          kbd_ack,
    input  logic          tick,
    output logic [1:0]    cur_dir,
    output logic          dir_upd,
    output logic          start_req,
    output logic          reset_req,
    output logic          running,
    output logic [CW-1:0] q_count,
    output logic          overflow
);

    state_t     state_q, state_d;
    logic       kbd_ack_q, kbd_ack_d;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic       dir_upd_q, dir_upd_d;
    logic       start_req_q, start_req_d;
    logic       reset_req_q, reset_req_d;
    logic       overflow_q, overflow_d;

    logic       take, press, in_run;
    logic       start_evt, reset_evt;
    logic [2:0] arrow;
    logic [1:0] ref_dir;
    logic       reversal, candidate;
    logic       fifo_push, fifo_pop;
    logic [1:0] fifo_head, fifo_tail;
    logic       fifo_full, fifo_empty;

    always_comb begin
        take      = kbd_valid & ~kbd_ack_q;
        press     = take & ~kbd_released;
        in_run    = (state_q == S_RUN);
        arrow     = decode_arrow(kbd_code);
        start_evt = ~in_run & press & (kbd_code == SC_START);
        reset_evt =  in_run & press & (kbd_code == SC_RESET);
        // Duplicate/reversal checks compare against the last direction the snake
        // will have taken, which is the queue tail whenever anything is queued.
        ref_dir   = fifo_empty ? cur_dir_q : fifo_tail;
`ifdef SNAKE_REVERSE_FILTER_EN
        reversal  = (arrow[1:0] == (ref_dir ^ 2'd2));
`else
        reversal  = 1'b0;
`endif
        fifo_pop  = in_run & tick & ~fifo_empty & ~reset_evt;
        candidate = in_run & press & arrow[2] & (arrow[1:0] != ref_dir) & ~reversal;
        fifo_push = candidate & (~fifo_full | fifo_pop);

        state_d     = state_q;
        cur_dir_d   = cur_dir_q;
        overflow_d  = overflow_q;
        kbd_ack_d   = take;
        dir_upd_d   = fifo_pop;
        start_req_d = start_evt;
        reset_req_d = reset_evt;

        if (start_evt) state_d = S_RUN;
        if (reset_evt) begin
            state_d    = S_IDLE;
            cur_dir_d  = INIT_DIR;
            overflow_d = 1'b0;
        end else begin
            if (fifo_pop) cur_dir_d = fifo_head;
            if (candidate & fifo_full & ~fifo_pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kbd_ack_q   <= 1'b0;
            cur_dir_q   <= INIT_DIR;
            dir_upd_q   <= 1'b0;
            start_req_q <= 1'b0;
            reset_req_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            kbd_ack_q   <= kbd_ack_d;
            cur_dir_q   <= cur_dir_d;
            dir_upd_q   <= dir_upd_d;
            start_req_q <= start_req_d;
            reset_req_q <= reset_req_d;
            overflow_q  <= overflow_d;
        end
    end

    snake_dir_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (reset_evt),
        .din   (arrow[1:0]),
        .head  (fifo_head),
        .tail  (fifo_tail),
        .count (q_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign kbd_ack   = kbd_ack_q;
    assign cur_dir   = cur_dir_q;
    assign dir_upd   = dir_upd_q;
    assign start_req = start_req_q;
    assign reset_req = reset_req_q;
    assign running   = (state_q == S_RUN);
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_dir_scheduler.sv
// ============================================================================
// tb_snake_dir_scheduler : directed plus random key-event stimulus checked
//                          against a queue-based behavioural model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_snake_dir_scheduler;

    localparam int QDEPTH = 4;
    localparam int CW     = $clog2(QDEPTH + 1);
`ifdef SNAKE_REVERSE_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          kbd_valid;
    logic [7:0]    kbd_code;
    logic          kbd_released;
    logic          kbd_ack;
    logic          tick;
    logic [1:0]    cur_dir;
    logic          dir_upd;
    logic          start_req;
    logic          reset_req;
    logic          running;
    logic [CW-1:0] q_count;
    logic          overflow;

    snake_dir_scheduler #(.QDEPTH(QDEPTH), .INIT_DIR(2'd1)) dut (
        .clk          (clk),
        .rst          (rst),
        .kbd_valid    (kbd_valid),
        .kbd_code     (kbd_code),
        .kbd_released (kbd_released),
        .kbd_ack      (kbd_ack),
        .tick         (tick),
        .cur_dir      (cur_dir),
        .dir_upd      (dir_upd),
        .start_req    (start_req),
        .reset_req    (reset_req),
        .running      (running),
        .q_count      (q_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] code; logic rel; } ev_t;
    ev_t ev_q[$];

    // Reference model state
    int mq[$];
    int m_cur;
    bit m_run, m_ovf, m_ack, m_upd, m_start, m_rstreq;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [7:0] c,
                              input bit rel, input bit t);
        bit take, press, is_arrow, pop;
        int d, refd;
        m_upd = 0; m_start = 0; m_rstreq = 0;
        if (r) begin
            mq.delete(); m_cur = 1; m_run = 0; m_ovf = 0; m_ack = 0;
            return;
        end
        take  = v && !m_ack;
        m_ack = take;
        press = take && !rel;
        is_arrow = 1; d = 0;
        case (c)
            8'h75:   d = 0;
            8'h74:   d = 1;
            8'h72:   d = 2;
            8'h6B:   d = 3;
            default: is_arrow = 0;
        endcase
        if (!m_run) begin
            if (press && c == 8'h5A) begin m_run = 1; m_start = 1; end
        end else if (press && c == 8'h76) begin
            mq.delete(); m_cur = 1; m_ovf = 0; m_run = 0; m_rstreq = 1;
        end else begin
            pop  = t && mq.size() > 0;
            refd = (mq.size() > 0) ? mq[$] : m_cur;
            if (pop) begin m_cur = mq.pop_front(); m_upd = 1; end
            if (press && is_arrow && d != refd && !(FILTER && d == (refd ^ 2))) begin
                if (mq.size() < QDEPTH) mq.push_back(d);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic check_all();
        check("kbd_ack",   8'(kbd_ack),   8'(m_ack));
        check("cur_dir",   8'(cur_dir),   8'(m_cur));
        check("dir_upd",   8'(dir_upd),   8'(m_upd));
        check("start_req", 8'(start_req), 8'(m_start));
        check("reset_req", 8'(reset_req), 8'(m_rstreq));
        check("running",   8'(running),   8'(m_run));
        check("q_count",   8'(q_count),   8'(mq.size()));
        check("overflow",  8'(overflow),  8'(m_ovf));
    endtask

    // One clock: emulate the receiver at the falling edge, step the model, check after the rise.
    task automatic cycle(input bit t, input bit r);
        ev_t e;
        @(negedge clk);
        if (kbd_valid && kbd_ack) kbd_valid = 1'b0;
        if (!kbd_valid && ev_q.size() > 0) begin
            e = ev_q.pop_front();
            kbd_valid    = 1'b1;
            kbd_code     = e.code;
            kbd_released = e.rel;
        end
        tick = t;
        rst  = r;
        model_step(r, kbd_valid, kbd_code, kbd_released, t);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic press_key(input logic [7:0] code, input bit rel);
        ev_t e;
        e.code = code; e.rel = rel;
        ev_q.push_back(e);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        ev_t e;
        logic [7:0] codes [8];
        int pick;
        codes[0] = 8'h75; codes[1] = 8'h72; codes[2] = 8'h6B; codes[3] = 8'h74;
        codes[4] = 8'h5A; codes[5] = 8'h76; codes[6] = 8'h1C; codes[7] = 8'hF0;

        rst = 1'b1; kbd_valid = 1'b0; kbd_code = 8'h00; kbd_released = 1'b0; tick = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

        // IDLE: arrow ignored, START enters RUN
        press_key(8'h75, 1'b0);
        press_key(8'h5A, 1'b0);
        // Two queued turns popped by two ticks
        press_key(8'h75, 1'b0);
        press_key(8'h6B, 1'b0);
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        // Five presses into a depth-4 queue
        press_key(8'h75, 1'b0);
        press_key(8'h6B, 1'b0);
        press_key(8'h72, 1'b0);
        press_key(8'h74, 1'b0);
        press_key(8'h75, 1'b0);
        // Drain, then duplicate and break handling
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        press_key(8'h75, 1'b0);
        press_key(8'h75, 1'b0);
        press_key(8'h75, 1'b1);
        // Reversal against an empty queue
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        press_key(8'h74, 1'b0);
        cycle(1'b1, 1'b0);
        press_key(8'h6B, 1'b0);
        // Fill to three, then RESET taken on the same edge as a tick
        press_key(8'h75, 1'b0);
        press_key(8'h6B, 1'b0);
        press_key(8'h72, 1'b0);
        e.code = 8'h76; e.rel = 1'b0;
        ev_q.push_back(e);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        // rst mid-RUN with a pending event
        press_key(8'h5A, 1'b0);
        press_key(8'h72, 1'b0);
        e.code = 8'h6B; e.rel = 1'b0;
        ev_q.push_back(e);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

        // Random phase
        for (int n = 0; n < 2000; n++) begin
            if (ev_q.size() == 0 && $urandom_range(0, 1) == 0) begin
                pick = $urandom_range(0, 99);
                if      (pick < 60) e.code = codes[$urandom_range(0, 3)];
                else if (pick < 72) e.code = codes[4];
                else if (pick < 75) e.code = codes[5];
                else                e.code = codes[$urandom_range(6, 7)];
                e.rel = ($urandom_range(0, 4) == 0);
                ev_q.push_back(e);
            end
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
